// File: rtl/cpu10_pkg.sv
// Shared definitions for the 10-bit single-cycle CPU: word geometry,
// well-known instruction words and the opcode field used by the decoder
// and by the per-task program ROMs.
package cpu10_pkg;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 10;

  // Opcode occupies the top nibble of the instruction word.
  localparam int OPC_W   = 4;
  localparam int OPC_MSB = DATA_W - 1;
  localparam int OPC_LSB = DATA_W - OPC_W;

  typedef enum logic [OPC_W-1:0] {
    OP_SUB   = 4'b0000,
    OP_HALT  = 4'b0010,
    OP_ADD   = 4'b0110,
    OP_LOAD  = 4'b1101,
    OP_STORE = 4'b1110
  } opcode_e;

  localparam logic [DATA_W-1:0] HALT_WORD = 10'b0010000010;
  localparam logic [DATA_W-1:0] NOP_WORD  = 10'b0000000000;

  // Extract the opcode field from an instruction word.
  function automatic opcode_e opcode_of(input logic [DATA_W-1:0] word);
    return opcode_e'(word[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/task1_rom.sv
// Fixed-content instruction ROM holding the Task-1 program. The read is
// registered: the word for the address seen at a rising edge appears on
// read_data after that edge. Reset clears only the output register.
module task1_rom #(
  parameter int                      DATA_W    = cpu10_pkg::DATA_W,
  parameter int                      ADDR_W    = cpu10_pkg::ADDR_W,
  parameter logic [DATA_W-1:0]       FILL_WORD = cpu10_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] read_data
);

  import cpu10_pkg::*;

  logic [DATA_W-1:0] read_data_d;
  logic [DATA_W-1:0] read_data_q;

  // Program image. Any address outside the program (including an unknown
  // address) returns FILL_WORD, so the stored contents can never be disturbed.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    case (a)
      ADDR_W'(0): rom_word = 10'b0000000001; // sub   t0,t0,t0
      ADDR_W'(1): rom_word = 10'b1101110000; // load  t1,0(s0)
      ADDR_W'(2): rom_word = 10'b1101011001; // load  s1,1(s0)
      ADDR_W'(3): rom_word = 10'b0110100000; // add   t1,t0,t1
      ADDR_W'(4): rom_word = 10'b1110110011; // store t1,2(s0)
      ADDR_W'(5): rom_word = HALT_WORD;      // halt
      default:    rom_word = FILL_WORD;
    endcase
  endfunction

  // Combinational ROM lookup for the current address.
  always_comb begin
    read_data_d = rom_word(address);
  end

  // Output register: cleared asynchronously, loaded every rising edge.
  // NOTE: the lookup stays a reset-free constant table so it maps to ROM;
  // resetting storage would force it into flops. Only this register resets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q <= NOP_WORD; // NOTE: non-blocking for all sequential state.
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_task1_rom.sv
// Self-checking bench for task1_rom: an array-based reference model is
// compared every falling edge, and directed vectors pin literal values.
module tb_task1_rom;

  localparam int DW = 10;
  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] address;
  logic [DW-1:0] read_data;

  int checks   = 0;
  int failures = 0;

  task1_rom #(.DATA_W(DW), .ADDR_W(AW), .FILL_WORD(10'b0010000010)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents table plus the rule "output = word captured
  // at the last edge, or zero while/after reset".
  logic [DW-1:0] golden [0:(1<<AW)-1];
  logic [DW-1:0] model_q;
  bit            model_on = 1'b0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) golden[i] = 10'b0010000010;
    golden[0] = 10'b0000000001;
    golden[1] = 10'b1101110000;
    golden[2] = 10'b1101011001;
    golden[3] = 10'b0110100000;
    golden[4] = 10'b1110110011;
    golden[5] = 10'b0010000010;
  end

  always @(posedge clk) if (rst_n === 1'b1) model_q <= golden[address];
  always @(rst_n) if (rst_n === 1'b0) model_q <= '0;

  always @(negedge clk) if (model_on) check("model", read_data, model_q);

  // Apply an address shortly after an edge, then check just after the next.
  task automatic read_at(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                         input string name);
    @(posedge clk); #2;
    address = a;
    @(posedge clk); #1;
    check(name, read_data, exp);
  endtask

  initial begin
    rst_n   = 1'b0;
    address = '0;
    model_q = '0;

    // Reset held across three edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold", read_data, 10'b0000000000);
    end
    model_on = 1'b1;

    // Release reset with address 0; first edge loads mem[0].
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_addr0", read_data, 10'b0000000001);

    // Sequential read / full program sweep.
    read_at(10'd1, 10'b1101110000, "addr1");
    read_at(10'd2, 10'b1101011001, "addr2");
    read_at(10'd0, 10'b0000000001, "addr0");
    read_at(10'd3, 10'b0110100000, "addr3");
    read_at(10'd4, 10'b1110110011, "addr4");
    read_at(10'd5, 10'b0010000010, "addr5");

    // Fill region and top of range.
    read_at(10'd6,    10'b0010000010, "fill6");
    read_at(10'd512,  10'b0010000010, "fill512");
    read_at(10'd1023, 10'b0010000010, "fill1023");

    // Latency: mid-cycle address change is invisible until the next edge.
    read_at(10'd3, 10'b0110100000, "lat_addr3");
    #3 address = 10'd4;
    #1 check("lat_hold", read_data, 10'b0110100000);
    @(posedge clk); #1;
    check("lat_update", read_data, 10'b1110110011);

    // Reset pulse mid-operation while reading address 4.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1 check("midreset_async", read_data, 10'b0000000000);
    #2 rst_n = 1'b1;
    #0 check("midreset_release", read_data, 10'b0000000000);
    @(posedge clk); #1;
    check("midreset_reload", read_data, 10'b1110110011);

    // A few more cycles for the model comparison.
    read_at(10'd2, 10'b1101011001, "post_addr2");
    read_at(10'd700, 10'b0010000010, "post_fill700");

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #20000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
